// File: rtl/opd_bus_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the memory-mapped output device.
// Each access runs IDLE -> ACC -> (HOLD)* -> RESP and ends with a one-cycle ack to the granted master.
module opd_bus_arbiter #(
  parameter int DW   = 32,
  parameter int HOLD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] rdata,
  output logic          dev_en,
  output logic [1:0]    dev_addr,
  output logic [DW-1:0] dev_din,
  input  logic [DW-1:0] dev_dout,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD, S_RESP} state_t;

  localparam logic [3:0] HOLD_INIT = 4'((HOLD > 0) ? HOLD - 1 : 0);

  state_t          state, state_nxt;
  logic            sel;
  logic            last_gnt;
  logic            lat_we;
  logic [1:0]      lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [3:0]      hold_cnt;
  logic            any_req;
  logic            win;

  assign any_req = m0_req | m1_req;
  // On a tie the master that was not granted last time wins.
  assign win     = (m0_req & m1_req) ? ~last_gnt : m1_req;

  // NOTE: assign state_nxt its default before the case so every path drives it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_req) state_nxt = S_ACC;
      S_ACC:  state_nxt = (HOLD > 0) ? S_HOLD : S_RESP;
      S_HOLD: if (hold_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 1'b0;
      last_gnt  <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= 2'b00;
      lat_wdata <= '0;
      hold_cnt  <= 4'd0;
      rdata     <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        sel       <= win;
        last_gnt  <= win;
        lat_we    <= win ? m1_we    : m0_we;
        lat_addr  <= win ? m1_addr  : m0_addr;
        lat_wdata <= win ? m1_wdata : m0_wdata;
      end
      if (state == S_ACC) begin
        rdata    <= dev_dout;
        hold_cnt <= HOLD_INIT;
      end else if (state == S_HOLD && hold_cnt != 4'd0) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
    end
  end

  // Outputs decode registered state only, so reset clears dev_en/ack/busy without waiting for a clock.
  assign dev_en   = (state == S_ACC) & lat_we;
  assign dev_addr = lat_addr;
  assign dev_din  = lat_wdata;
  assign m0_ack   = (state == S_RESP) & ~sel;
  assign m1_ack   = (state == S_RESP) &  sel;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_opd_bus_arbiter.sv
// Self-checking bench for opd_bus_arbiter: scoreboarded master transfers against a register-file device model,
// with a HOLD=0 instance for arbitration/data checks and a HOLD=3 instance for settling-latency checks.
module tb_opd_bus_arbiter;
  localparam int DW = 32;

  typedef struct {
    int            m;
    logic          we;
    logic [1:0]    addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req, we, ack;
  logic [1:0]    addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata, dev_din, dev_dout;
  logic [1:0]    dev_addr;
  logic          dev_en, busy;

  logic          h_req, h_we, h_ack, h_ack1, h_en, h_busy;
  logic [1:0]    h_addr, h_daddr;
  logic [DW-1:0] h_wdata, h_rdata, h_din, h_dout;

  logic [DW-1:0] dev_regs [4] = '{default: '0};
  logic [DW-1:0] h_regs [4]   = '{default: '0};

  int   n_vec = 0, n_fail = 0, cyc = 0;
  int   en_cnt = 0, en_cyc = -1, h_en_cnt = 0, h_busy_cnt = 0;
  logic [1:0] prev_ack = 2'b00;
  txn_t exp_q[$];
  txn_t vec[8];

  opd_bus_arbiter #(.DW(DW), .HOLD(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_ack(ack[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_ack(ack[1]),
    .rdata(rdata), .dev_en(dev_en), .dev_addr(dev_addr), .dev_din(dev_din), .dev_dout(dev_dout),
    .busy(busy)
  );

  opd_bus_arbiter #(.DW(DW), .HOLD(3)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .m0_req(h_req), .m0_we(h_we), .m0_addr(h_addr), .m0_wdata(h_wdata), .m0_ack(h_ack),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(2'b00), .m1_wdata('0), .m1_ack(h_ack1),
    .rdata(h_rdata), .dev_en(h_en), .dev_addr(h_daddr), .dev_din(h_din), .dev_dout(h_dout),
    .busy(h_busy)
  );

  // Device models: four registers, written on the rising edge while en is high.
  assign dev_dout = dev_regs[dev_addr];
  assign h_dout   = h_regs[h_daddr];
  initial forever begin
    @(posedge clk);
    if (dev_en) dev_regs[dev_addr] <= dev_din;
    if (h_en)   h_regs[h_daddr]    <= h_din;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the in-flight transfer; every ack pops the scoreboard.
  initial forever begin
    @(negedge clk);
    if (dev_en) begin
      en_cnt++;
      en_cyc = cyc;
      if (exp_q.size() == 0) check("dev_en_unexpected", 32'(dev_en), 32'd0);
      else begin
        check("dev_en_on_write", 32'(exp_q[0].we), 32'd1);
        check("dev_addr", 32'(dev_addr), 32'(exp_q[0].addr));
        check("dev_din", dev_din, exp_q[0].wdata);
      end
    end
    if (ack != 2'b00) begin
      txn_t t;
      check("ack_width", 32'(prev_ack & ack), 32'd0);
      if (exp_q.size() == 0) check("ack_unexpected", 32'(ack), 32'd0);
      else begin
        t = exp_q.pop_front();
        check("ack_master", 32'(ack), (t.m == 1) ? 32'd2 : 32'd1);
        if (!t.we) check("rdata", rdata, t.rd);
      end
    end
    prev_ack = ack;
    if (h_en)   h_en_cnt++;
    if (h_busy) h_busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input logic w, input logic [1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] rd);
    txn_t t;
    t.m = m; t.we = w; t.addr = a; t.wdata = d; t.rd = rd;
    exp_q.push_back(t);
  endtask

  // Raise req with payload, wait (bounded) for this master's ack, then drop req after the ack cycle.
  task automatic xfer(input int m, input logic w, input logic [1:0] a, input logic [DW-1:0] d,
                      output int ack_cyc);
    int n;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
    n = 0;
    ack_cyc = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (ack[m]) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) check("ack_timeout", 32'd0, 32'd1);
    tick();
    req[m] = 1'b0;
  endtask

  task automatic h_xfer(input logic w, input logic [1:0] a, input logic [DW-1:0] d, output int ack_cyc);
    int n;
    h_req = 1'b1; h_we = w; h_addr = a; h_wdata = d;
    n = 0;
    ack_cyc = -1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (h_ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) check("hold_ack_timeout", 32'd0, 32'd1);
    tick();
    h_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 2'b00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int s, c0, c1, e0, b0, n;
    req = 2'b00; we = 2'b00;
    addr = '{default: '0}; wdata = '{default: '0};
    h_req = 1'b0; h_we = 1'b0; h_addr = 2'b00; h_wdata = '0;

    vec[0] = '{0, 1'b1, 2'd1, 32'h1111_1111, 32'h0};
    vec[1] = '{1, 1'b1, 2'd2, 32'h2222_2222, 32'h0};
    vec[2] = '{1, 1'b1, 2'd3, 32'h3C3C_3C3C, 32'h0};
    vec[3] = '{0, 1'b0, 2'd1, 32'h0,         32'h1111_1111};
    vec[4] = '{1, 1'b0, 2'd3, 32'h0,         32'h3C3C_3C3C};
    vec[5] = '{0, 1'b0, 2'd2, 32'h0,         32'h2222_2222};
    vec[6] = '{0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
    vec[7] = '{1, 1'b0, 2'd0, 32'h0,         32'hFFFF_FFFF};

    // Reset values
    repeat (2) tick();
    check("rst_dev_en", 32'(dev_en), 32'd0);
    check("rst_dev_addr", 32'(dev_addr), 32'd0);
    check("rst_dev_din", dev_din, 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write from master 0
    s = cyc; e0 = en_cnt;
    push(0, 1'b1, 2'd0, 32'h1234_5678, 32'h0);
    xfer(0, 1'b1, 2'd0, 32'h1234_5678, c0);
    check("wr_ack_latency", 32'(c0 - s), 32'd2);
    check("wr_en_cycle", 32'(en_cyc - s), 32'd1);
    check("wr_en_width", 32'(en_cnt - e0), 32'd1);
    check("wr_dev_reg0", dev_regs[0], 32'h1234_5678);
    check("wr_addr_held", 32'(dev_addr), 32'd0);
    check("wr_din_held", dev_din, 32'h1234_5678);

    // Read back from master 1
    e0 = en_cnt;
    push(1, 1'b0, 2'd0, 32'h0, 32'h1234_5678);
    xfer(1, 1'b0, 2'd0, 32'h0, c1);
    check("rd_no_dev_en", 32'(en_cnt - e0), 32'd0);

    // Contention straight after reset: master 0 wins the first tie
    apply_reset();
    push(0, 1'b1, 2'd1, 32'h8765_4321, 32'h0);
    push(1, 1'b1, 2'd0, 32'h0, 32'h0);
    s = cyc;
    fork
      xfer(0, 1'b1, 2'd1, 32'h8765_4321, c0);
      xfer(1, 1'b1, 2'd0, 32'h0, c1);
    join
    check("cont_m0_latency", 32'(c0 - s), 32'd2);
    check("cont_ack_spacing", 32'(c1 - c0), 32'd3);
    check("cont_reg1", dev_regs[1], 32'h8765_4321);
    check("cont_reg0", dev_regs[0], 32'h0);

    // Fairness: m0 writes, m1 reads the same register; alternation makes each read see the preceding write
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 2'd2, 32'hA0A0_0000 + 32'(i), 32'h0);
      push(1, 1'b0, 2'd2, 32'h0, 32'hA0A0_0000 + 32'(i));
    end
    fork
      begin
        int d0;
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 2'd2, 32'hA0A0_0000 + 32'(i), d0);
      end
      begin
        int d1;
        for (int i = 0; i < 4; i++) xfer(1, 1'b0, 2'd2, 32'h0, d1);
      end
    join

    // Table of single-master accesses
    for (int i = 0; i < 8; i++) begin
      s = cyc;
      push(vec[i].m, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].rd);
      xfer(vec[i].m, vec[i].we, vec[i].addr, vec[i].wdata, c0);
      check("tbl_ack_latency", 32'(c0 - s), 32'd2);
    end

    // HOLD=3 instance: write, then read back
    s = cyc; e0 = h_en_cnt; b0 = h_busy_cnt;
    h_xfer(1'b1, 2'd1, 32'hCAFE_F00D, c0);
    repeat (2) tick();
    check("hold_ack_latency", 32'(c0 - s), 32'd5);
    check("hold_en_width", 32'(h_en_cnt - e0), 32'd1);
    check("hold_busy_cycles", 32'(h_busy_cnt - b0), 32'd5);
    check("hold_dev_reg1", h_regs[1], 32'hCAFE_F00D);
    s = cyc;
    h_xfer(1'b0, 2'd1, 32'h0, c0);
    check("hold_rd_latency", 32'(c0 - s), 32'd5);
    check("hold_rdata", h_rdata, 32'hCAFE_F00D);

    // Async reset while dev_en is high: access aborted, no write lands, no ack
    push(0, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'h0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 2'd3; wdata[0] = 32'hDEAD_BEEF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dev_en && n < 10);
    check("abort_saw_dev_en", 32'(dev_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_dev_en", 32'(dev_en), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dev_addr", 32'(dev_addr), 32'd0);
    exp_q.delete();
    req[0] = 1'b0;
    tick();
    check("abort_no_write", dev_regs[3], 32'h3C3C_3C3C);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // First tie after that reset goes to master 0; m1 reads what m0 just wrote
    push(0, 1'b1, 2'd3, 32'h3333_0000, 32'h0);
    push(1, 1'b0, 2'd3, 32'h0, 32'h3333_0000);
    s = cyc;
    fork
      xfer(0, 1'b1, 2'd3, 32'h3333_0000, c0);
      xfer(1, 1'b0, 2'd3, 32'h0, c1);
    join
    check("post_rst_m0_first", 32'(c0 - s), 32'd2);
    check("post_rst_spacing", 32'(c1 - c0), 32'd3);

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
